instr_prefetch: RTL and testbench
=================================

# instr_prefetch

Sequential instruction prefetcher feeding the CPU fetch stage. Issues 32-bit instruction fetch requests on the memory-bus upstream port of the 32→16 bus downconverter, buffers returned instructions with their addresses in a small FIFO, and hands them to the decode stage over a valid/ready handshake. Handles branch redirects (flush) without aborting a fetch already presented to the downconverter.

## Interface
- `AW`, 16: instruction address width; one address unit = one 32-bit instruction.
- `IW`, 32: instruction width.
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `RESET_PC`, 0: first fetch address after reset.

- `i_clk` in 1: clock, all state on rising edge.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_flush` in 1: redirect request, single-cycle pulse.
- `i_flush_pc` in AW: new fetch address, sampled when `i_flush`=1.
- `o_instr` out IW: head instruction.
- `o_instr_pc` out AW: address of `o_instr`.
- `o_valid` out 1: head entry valid.
- `i_ready` in 1: consumer accepts head when `o_valid & i_ready`.
- `o_req_addr` out AW: fetch address to downconverter.
- `o_req_active` out 1: fetch request active.
- `i_req_data` in IW: fetched instruction.
- `i_req_data_valid` in 1: one-cycle pulse, fetch complete.

## Operation
- Fetch FSM states: IDLE (`o_req_active`=0), FETCH (active, result kept), DISCARD (active, result dropped).
- `o_req_addr`/`o_req_active` are registered; while active, `o_req_addr` stays stable until the cycle of `i_req_data_valid` inclusive (downconverter derives both half-word addresses from it).
- At most one request outstanding.
- IDLE→FETCH when `count < DEPTH` (count after this cycle's pop), at `o_req_addr = pc`.
- FETCH on `i_req_data_valid`: push {`i_req_data`, `o_req_addr`}; pc ← pc+1 (wraps mod 2^AW); next cycle either FETCH at new pc if space remains (count+1 < DEPTH, counting a same-cycle pop), otherwise IDLE.
- Flush: FIFO cleared; pc ← `i_flush_pc`. In FETCH with no data-valid in the same cycle → DISCARD (address held). In FETCH with data-valid in the same cycle → data dropped, next cycle FETCH at `i_flush_pc`. In IDLE → FETCH at `i_flush_pc` next cycle.
- DISCARD on `i_req_data_valid`: data dropped, next cycle FETCH at pc. A second flush in DISCARD only updates pc.
- Flush has priority over push and pop in the same cycle; a pop coincident with flush is ignored (`o_valid` still reflects pre-flush state that cycle; consumer must ignore it during flush).
- FIFO: circular, log2(DEPTH)-bit pointers plus count (log2(DEPTH)+1 bits); simultaneous push and pop at full or empty are legal (see Configuration for empty).

## Timing
- Reset values: `o_req_active`=0, `o_req_addr`=`RESET_PC`, `o_valid`=0, `o_instr`=0, `o_instr_pc`=0, pc=`RESET_PC`, FIFO empty, state IDLE.
- First request: `o_req_active`=1 on first clock edge after `i_rst_n` deasserts.
- Request-to-request: `i_req_data_valid` at cycle N → next address driven at cycle N+1.
- Push-to-output: entry visible on `o_valid` at cycle N+1 (without bypass).
- Flush-to-request: new address on `o_req_addr` one cycle after flush (IDLE or coincident data-valid), else one cycle after the discarded data-valid.
- Reset asserted mid-fetch: all state returns to reset values immediately; downconverter reset by same domain.

## Configuration
- `PREFETCH_BYPASS_EN` defined: when FIFO empty, not flushing, and `i_req_data_valid`=1 in FETCH, the data and address appear combinationally on `o_instr`/`o_instr_pc` with `o_valid`=1 in cycle N; if `i_ready`=1 it is consumed and not written to the FIFO.
- Undefined: outputs driven only from FIFO head; `o_valid` purely registered; one extra cycle latency.

## Test plan
- Reset with `RESET_PC`=0x0100, `i_ready`=1, memory model answering 3 cycles after each request → `o_instr_pc` sequence 0x0100,0x0101,0x0102… with one request outstanding.
- `i_ready`=0, DEPTH=4 → exactly 4 pushes, `o_req_active`=0 afterward; raise `i_ready` for one cycle → one new request issued at 0x0104.
- Flush to 0x0200 two cycles into a fetch of 0x0105 → `o_req_addr` held at 0x0105 until data-valid, that data not output, next request 0x0200, first `o_instr_pc`=0x0200.
- Flush coincident with `i_req_data_valid` → data dropped, next-cycle `o_req_addr`=flush pc, FIFO empty.
- pc=0xFFFF fetch → next request address 0x0000.
- `i_rst_n` low mid-fetch with 2 entries queued → `o_valid`=0, `o_req_active`=0 immediately; bypass build: empty FIFO with data-valid → `o_valid`=1 in same cycle.

Source files
------------

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: one outstanding fetch, small FIFO, flush redirect.
// Define PREFETCH_BYPASS_EN to forward returning data straight to the consumer when the FIFO is empty.
module instr_prefetch #(
  parameter int unsigned    AW       = 16,
  parameter int unsigned    IW       = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic [AW-1:0] i_flush_pc,
  output logic [IW-1:0] o_instr,
  output logic [AW-1:0] o_instr_pc,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [AW-1:0] o_req_addr,
  output logic          o_req_active,
  input  logic [IW-1:0] i_req_data,
  input  logic          i_req_data_valid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD} state_e;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   req_addr_q, req_addr_d;
  logic            req_active_q, req_active_d;
  logic            valid_q, valid_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];

  logic            byp_c;
  logic            push_c;
  logic            pop_c;
  logic            space_c;
  logic [AW-1:0]   redirect_pc_c;
  entry_t          head_c;

  // FIFO bookkeeping; flush wins over push and pop
  always_comb begin
    byp_c    = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    byp_c    = (state_q == S_FETCH) & i_req_data_valid & ~i_flush & (count_q == '0);
`endif
    pop_c    = valid_q & i_ready & ~i_flush;
    push_c   = (state_q == S_FETCH) & i_req_data_valid & ~i_flush & ~(byp_c & i_ready);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        mem_d[wr_ptr_q] = entry_t'{pc: req_addr_q, instr: i_req_data};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    valid_d = (count_d != '0);
    space_c = (count_d < CW'(DEPTH));
  end

  // Fetch FSM; the request address is held from issue through its data-valid cycle
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    req_active_d  = req_active_q;
    redirect_pc_c = i_flush ? i_flush_pc : pc_q;

    case (state_q)
      S_IDLE: begin
        pc_d = redirect_pc_c;
        if (i_flush || space_c) begin
          state_d      = S_FETCH;
          req_addr_d   = redirect_pc_c;
          req_active_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (i_flush) begin
          pc_d = i_flush_pc;
          if (i_req_data_valid) begin
            req_addr_d = i_flush_pc;
          end else begin
            state_d = S_DISCARD;
          end
        end else if (i_req_data_valid) begin
          pc_d = pc_q + AW'(1);
          if (space_c) begin
            req_addr_d = pc_q + AW'(1);
          end else begin
            state_d      = S_IDLE;
            req_active_d = 1'b0;
          end
        end
      end
      S_DISCARD: begin
        pc_d = redirect_pc_c;
        if (i_req_data_valid) begin
          state_d    = S_FETCH;
          req_addr_d = redirect_pc_c;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      req_active_q <= 1'b0;
      valid_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      req_active_q <= req_active_d;
      valid_q      <= valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
    end
  end

  assign head_c       = mem_q[rd_ptr_q];
  assign o_req_addr   = req_addr_q;
  assign o_req_active = req_active_q;

`ifdef PREFETCH_BYPASS_EN
  assign o_valid    = valid_q | byp_c;
  assign o_instr    = byp_c ? i_req_data : head_c.instr;
  assign o_instr_pc = byp_c ? req_addr_q : head_c.pc;
`else
  assign o_valid    = valid_q;
  assign o_instr    = head_c.instr;
  assign o_instr_pc = head_c.pc;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: memory responder, scoreboard of expected fetch addresses.
module tb_instr_prefetch;

  localparam int unsigned AW      = 16;
  localparam int unsigned IW      = 32;
  localparam int unsigned DEPTH   = 4;
  localparam logic [15:0] RPC     = 16'h0100;
  localparam int          MEM_LAT = 3;
`ifdef PREFETCH_BYPASS_EN
  localparam logic        BYP     = 1'b1;
`else
  localparam logic        BYP     = 1'b0;
`endif

  logic          i_clk;
  logic          i_rst_n;
  logic          i_flush;
  logic [AW-1:0] i_flush_pc;
  logic [IW-1:0] o_instr;
  logic [AW-1:0] o_instr_pc;
  logic          o_valid;
  logic          i_ready;
  logic [AW-1:0] o_req_addr;
  logic          o_req_active;
  logic [IW-1:0] i_req_data;
  logic          i_req_data_valid;

  int            n_checks;
  int            n_fail;
  int            n_consumed;
  logic [15:0]   exp_q[$];
  logic [15:0]   mon_pc;
  logic [15:0]   mem_req_a;
  int            mem_cnt;

  instr_prefetch #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_flush          (i_flush),
    .i_flush_pc       (i_flush_pc),
    .o_instr          (o_instr),
    .o_instr_pc       (o_instr_pc),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_req_addr       (o_req_addr),
    .o_req_active     (o_req_active),
    .i_req_data       (i_req_data),
    .i_req_data_valid (i_req_data_valid)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic push_seq(input logic [15:0] start, input int n);
    logic [15:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 16'd1;
    end
  endtask

  task automatic wait_dv(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!i_req_data_valid && k < 60);
    check(tag, 32'(i_req_data_valid), 32'd1);
  endtask

  task automatic wait_addr(input logic [15:0] a, input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(o_req_active && o_req_addr == a) && k < 100);
    check(tag, 32'(o_req_addr), 32'(a));
  endtask

  task automatic wait_addr_change(input logic [15:0] a);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (o_req_addr == a && k < 60);
  endtask

  task automatic wait_consumed(input int n, input string tag);
    int start;
    int k;
    start = n_consumed;
    k = 0;
    while (n_consumed < start + n && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(n_consumed - start >= n), 32'd1);
  endtask

  // Memory model: answers MEM_LAT cycles after a request is seen, one-cycle data-valid
  initial begin
    i_req_data_valid = 1'b0;
    i_req_data       = '0;
    mem_cnt          = 0;
    mem_req_a        = '0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!i_rst_n || !o_req_active || i_req_data_valid) begin
        i_req_data_valid = 1'b0;
        i_req_data       = '0;
        mem_cnt          = 0;
      end else begin
        mem_cnt++;
        if (mem_cnt == 1) mem_req_a = o_req_addr;
        if (mem_cnt == MEM_LAT) begin
          check("req_addr_stable", 32'(o_req_addr), 32'(mem_req_a));
          i_req_data_valid = 1'b1;
          i_req_data       = mem_word(o_req_addr);
        end
      end
    end
  end

  // Consumer-side scoreboard compare on each accepted handshake
  always @(negedge i_clk) begin
    if (i_rst_n && !i_flush && o_valid && i_ready) begin
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_pc = exp_q.pop_front();
        check("out_pc", 32'(o_instr_pc), 32'(mon_pc));
        check("out_instr", o_instr, mem_word(mon_pc));
      end
      n_consumed++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    n_consumed = 0;
    i_clk      = 1'b0;
    i_rst_n    = 1'b0;
    i_flush    = 1'b0;
    i_flush_pc = '0;
    i_ready    = 1'b0;

    repeat (2) @(posedge i_clk);
    #2;
    check("rst_req_active", 32'(o_req_active), 32'd0);
    check("rst_req_addr",   32'(o_req_addr),   32'(RPC));
    check("rst_valid",      32'(o_valid),      32'd0);
    check("rst_instr",      o_instr,           32'd0);
    check("rst_instr_pc",   32'(o_instr_pc),   32'd0);

    push_seq(RPC, 16);
    i_rst_n = 1'b1;
    tick();
    check("first_req_active", 32'(o_req_active), 32'd1);
    check("first_req_addr",   32'(o_req_addr),   32'(RPC));

    // Consumer stalled: FIFO fills with exactly DEPTH entries and fetching stops
    repeat (30) tick();
    check("full_idle",       32'(o_req_active), 32'd0);
    check("full_valid",      32'(o_valid),      32'd1);
    check("full_head_pc",    32'(o_instr_pc),   32'h0100);
    check("full_head_instr", o_instr,           mem_word(16'h0100));

    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("refill_active", 32'(o_req_active), 32'd1);
    check("refill_addr",   32'(o_req_addr),   32'h0104);
    repeat (12) tick();
    check("refull_idle",    32'(o_req_active), 32'd0);
    check("refull_head_pc", 32'(o_instr_pc),   32'h0101);

    // Flush two cycles into the 0x0105 fetch
    i_ready = 1'b1;
    wait_addr(16'h0105, "fetch_105");
    tick();
    i_flush    = 1'b1;
    i_flush_pc = 16'h0200;
    exp_q.delete();
    push_seq(16'h0200, 16);
    tick();
    i_flush = 1'b0;
    check("discard_active",    32'(o_req_active), 32'd1);
    check("discard_addr_hold", 32'(o_req_addr),   32'h0105);
    wait_addr_change(16'h0105);
    check("redirect_addr",  32'(o_req_addr), 32'h0200);
    check("redirect_valid", 32'(o_valid),    32'd0);
    wait_dv("byp_dv");
    check("byp_valid", 32'(o_valid), 32'(BYP));
    wait_consumed(4, "stream_200");

    // Flush coincident with data-valid while entries are queued
    i_ready = 1'b0;
    wait_dv("fill_dv1");
    wait_dv("fill_dv2");
    check("pre_flush_valid", 32'(o_valid), 32'd1);
    i_flush    = 1'b1;
    i_flush_pc = 16'h0300;
    exp_q.delete();
    push_seq(16'h0300, 16);
    tick();
    i_flush = 1'b0;
    check("fdv_addr",   32'(o_req_addr),   32'h0300);
    check("fdv_active", 32'(o_req_active), 32'd1);
    check("fdv_valid",  32'(o_valid),      32'd0);
    i_ready = 1'b1;
    wait_consumed(3, "stream_300");

    // Address wrap past 0xFFFF
    i_flush    = 1'b1;
    i_flush_pc = 16'hFFFE;
    exp_q.delete();
    push_seq(16'hFFFE, 8);
    tick();
    i_flush = 1'b0;
    wait_addr(16'hFFFF, "fetch_ffff");
    wait_addr_change(16'hFFFF);
    check("wrap_addr", 32'(o_req_addr), 32'h0000);
    wait_consumed(4, "stream_wrap");

    // Asynchronous reset mid-fetch with entries queued
    i_ready = 1'b0;
    wait_dv("rq_dv1");
    wait_dv("rq_dv2");
    tick();
    check("rq_valid",  32'(o_valid),      32'd1);
    check("rq_active", 32'(o_req_active), 32'd1);
    #1;
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rstm_valid",    32'(o_valid),      32'd0);
    check("rstm_active",   32'(o_req_active), 32'd0);
    check("rstm_addr",     32'(o_req_addr),   32'(RPC));
    check("rstm_instr_pc", 32'(o_instr_pc),   32'd0);
    push_seq(RPC, 8);
    tick();
    i_rst_n = 1'b1;
    tick();
    check("rel_active", 32'(o_req_active), 32'd1);
    check("rel_addr",   32'(o_req_addr),   32'(RPC));
    i_ready = 1'b1;
    wait_consumed(3, "stream_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
